// File: rtl/pingpong_frame_store.sv
// Double-buffered frame store: writes land in bank ~bank_sel, reads come from bank_sel, and banks swap on flip_req.
// Define PINGPONG_CLEAR_EN to sweep CLEAR_VALUE through the new write bank after every swap.
module pingpong_frame_store #(
  parameter int                   NUM_WR      = 1,
  parameter int                   NUM_RD      = 4,
  parameter int                   ADDR_SIZE   = 16,
  parameter int                   DATA_SIZE   = 1,
  parameter int                   DEPTH       = 4096,
  parameter logic [DATA_SIZE-1:0] CLEAR_VALUE = '0
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic [NUM_WR-1:0]                    wr_en,
  input  logic [NUM_WR-1:0][ADDR_SIZE-1:0]     wr_addr,
  input  logic [NUM_WR-1:0][DATA_SIZE-1:0]     wr_data,
  input  logic [NUM_RD-1:0]                    rd_en,
  input  logic [NUM_RD-1:0][ADDR_SIZE-1:0]     rd_addr,
  output logic [NUM_RD-1:0][DATA_SIZE-1:0]     rd_data,
  output logic [NUM_RD-1:0]                    rd_valid,
  input  logic                                 flip_req,
  output logic                                 flip_done,
  output logic                                 wr_ready,
  output logic                                 bank_sel
);

  localparam int                   IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_SIZE:0]   DEPTH_LIM = (ADDR_SIZE + 1)'(DEPTH);

`ifdef PINGPONG_CLEAR_EN
  typedef enum logic [1:0] {IDLE, SWAP, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SWAP} state_t;
`endif

  state_t                           state_q, state_d;
  logic                             bank_sel_q, bank_sel_d;
  logic                             flip_done_q, flip_done_d;
  logic [NUM_RD-1:0][DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]                rd_valid_q, rd_valid_d;
  logic [NUM_WR-1:0]                wr_fire;
  logic [NUM_RD-1:0]                rd_in_range;
  logic                             wr_bank;
  logic                             idle;
  logic [DATA_SIZE-1:0]             mem_q [2][DEPTH];
`ifdef PINGPONG_CLEAR_EN
  logic [IDX_W-1:0]                 clr_cnt_q, clr_cnt_d;
`endif

  assign idle      = (state_q == IDLE);
  // Held low for the whole reset interval, high from the first cycle after release.
  assign wr_ready  = idle & n_rst;
  assign wr_bank   = ~bank_sel_q;
  assign bank_sel  = bank_sel_q;
  assign flip_done = flip_done_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
      assign wr_fire[gi] = wr_en[gi] & wr_ready & ({1'b0, wr_addr[gi]} < DEPTH_LIM);
    end
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      assign rd_in_range[gi] = ({1'b0, rd_addr[gi]} < DEPTH_LIM);
    end
  endgenerate

  // Highest channel is applied first so the lowest colliding channel lands last and wins.
  always_ff @(posedge clk) begin
`ifdef PINGPONG_CLEAR_EN
    if (state_q == CLEAR) begin
      mem_q[wr_bank][clr_cnt_q] <= CLEAR_VALUE;
    end
`endif
    for (int i = NUM_WR - 1; i >= 0; i--) begin
      if (wr_fire[i]) begin
        mem_q[wr_bank][wr_addr[i][IDX_W-1:0]] <= wr_data[i];
      end
    end
  end

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    for (int j = 0; j < NUM_RD; j++) begin
      if (rd_en[j]) begin
        rd_data_d[j] = rd_in_range[j] ? mem_q[bank_sel_q][rd_addr[j][IDX_W-1:0]] : '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    flip_done_d = 1'b0;
`ifdef PINGPONG_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (flip_req) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        bank_sel_d = ~bank_sel_q;
`ifdef PINGPONG_CLEAR_EN
        state_d    = CLEAR;
        clr_cnt_d  = '0;
`else
        state_d     = IDLE;
        flip_done_d = 1'b1;
`endif
      end
`ifdef PINGPONG_CLEAR_EN
      CLEAR: begin
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d     = IDLE;
          flip_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + IDX_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      bank_sel_q  <= 1'b0;
      flip_done_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= '0;
`ifdef PINGPONG_CLEAR_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      flip_done_q <= flip_done_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
`ifdef PINGPONG_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

endmodule
